cambus_timing: RTL and testbench
================================

# cambus_timing

Parametrised single-clock successor to the camera-bus blanking logic. Consumes a strobed pixel stream plus hsync/vsync already in the 50 MHz domain, sits downstream of the clock-crossing FIFO, and regenerates pixel/line coordinates and blanking. Replaces the always-locked stub with a real lock detector that measures line length and frame height, and adds a test-pattern mode.

## Interface
- PIX_W, 12: pixel data width
- CNT_W, 9: x/y counter width; counters saturate at 2^CNT_W-1
- H_ACTIVE, 320: visible pixels per line, starting at x=0
- V_FIRST, 1: first visible line
- V_ACTIVE, 256: visible lines
- LOCK_FRAMES, 2: consecutive matching frames required to lock
- TIMEOUT_CYC, 4096: clk cycles without an hsync rise before forced unlock
- clk  in  1  system clock; one clock, all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  pixel beat strobe; edges are sampled only on these beats
- in_pixel  in  PIX_W  pixel data
- in_hsync, in_vsync  in  1  sync levels; the rising edge marks line/frame start
- test_pattern  in  1  substitute a generated pattern for the camera data
- out_valid  out  1  output beat strobe
- out_pixel  out  PIX_W  masked or pattern pixel
- out_x, out_y  out  CNT_W  beat coordinates
- out_hblank, out_vblank, out_visible  out  1  blanking flags
- out_locked  out  1  lock status
- out_sof  out  1  first visible pixel of frame

## Operation
- Edge detect: keep last_hsync/last_vsync, updated only on in_valid beats. A rise is last=0 and current=1.
- Counters are computed for each beat, then registered:
  - hsync rise: x=0 and y=y+1.
  - Otherwise: x=x+1.
  - vsync rise: y=0. This wins over y+1 when both rise on the same beat.
  - Both counters saturate and never wrap.
- Visibility: h_vis = x<H_ACTIVE; v_vis = V_FIRST<=y<V_FIRST+V_ACTIVE.
- Masking: out_hblank=!h_vis||!locked, out_vblank=!v_vis||!locked, out_visible=!out_hblank&&!out_vblank.
- Pixel output:
  - Not visible: out_pixel = 0.
  - Visible with test_pattern=1: (x+y) mod 2^PIX_W.
  - Visible otherwise: in_pixel.
- out_sof = visible && x==0 && y==V_FIRST.
- Lock FSM, with states UNLOCKED, MEASURE, VERIFY, LOCKED:
  - UNLOCKED: on vsync rise, go to MEASURE and clear ref_len_valid.
  - MEASURE: on each hsync rise with y>=1, the completed line length is x+1. The first one is captured as ref_len. Any later one that differs returns the FSM to UNLOCKED. On vsync rise, capture ref_lines=y, set match=0, go to VERIFY.
  - VERIFY: check line lengths the same way. On vsync rise, y==ref_lines gives match+1, and reaching LOCK_FRAMES goes to LOCKED. y!=ref_lines goes to UNLOCKED.
  - LOCKED: any line-length or frame-height mismatch goes to UNLOCKED.
  - Any state: timeout goes to UNLOCKED.
- Timeout counter: counts clk cycles, not beats. It is cleared on every hsync-rise beat and saturates. Reaching TIMEOUT_CYC forces UNLOCKED; this catches a stopped camera clock.
- Counter saturation counts as a mismatch in MEASURE, VERIFY and LOCKED.

## Timing
- Latency: out_valid = in_valid delayed by 1 clk. All out_* are registered and aligned to the same beat.
- out_locked reflects the FSM state after the beat is processed:
  - The vsync beat that completes verification outputs locked=1.
  - A mismatching beat outputs locked=0.
  - A timeout drops locked 1 clk after the counter reaches TIMEOUT_CYC, even with no beat.
- Non-valid cycles: out_valid=0, other outputs hold.
- Reset values:
  - Outputs: out_valid=0, out_pixel=0, out_x=0, out_y=0, out_hblank=1, out_vblank=1, out_visible=0, out_locked=0, out_sof=0.
  - Internal: FSM=UNLOCKED, last_*=0, counters=0.
- Reset mid-frame takes priority over everything. The next frame must go through the full acquisition sequence again.
- test_pattern is sampled per beat; no frame alignment.

## Structure
- cambus_pkg:
  - lock_state_t enum (UNLOCKED, MEASURE, VERIFY, LOCKED)
  - helper constant for the timeout counter width, $clog2(TIMEOUT_CYC+1)
- Sub-module cambus_lockfsm:
  - Inputs: edge strobes, x/y, saturation flags.
  - Output: locked.
  - Contains the FSM, ref_len, ref_lines, match and timeout.
- Top level holds edge detect, counters, masking and the output register.

## Test plan
- Reset, then 4 frames of 262 lines × 400 beats:
  - out_locked rises on the 4th vsync-rise beat.
  - Visible beats have x 0..319 and y 1..256.
  - out_sof fires once per frame after lock.
- While locked, one line is 399 beats: out_locked=0 on the next hsync beat; relock on the 4th vsync after that.
- While locked, a frame has 261 lines: unlock on that vsync beat.
- Stop in_valid for 4096 clk: out_locked falls at cycle 4097; out_valid stays 0.
- test_pattern=1 while locked: x=5, y=3 gives out_pixel=8. Beats with x≥320 give 0.
- hsync and vsync rise on the same beat: y=0, x=0. rst asserted mid-line: reset values on the next clk.

Source files
------------

// File: rtl/cambus_pkg.sv
// Shared types and helpers for the camera-bus timing regenerator.
package cambus_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    MEASURE  = 2'd1,
    VERIFY   = 2'd2,
    LOCKED   = 2'd3
  } lock_state_t;

  function automatic int tmo_width(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/cambus_lockfsm.sv
// Lock detector: learns line length and frame height, then requires
// LOCK_FRAMES matching frames before declaring lock.
module cambus_lockfsm
  import cambus_pkg::*;
#(
  parameter int CNT_W       = 9,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat_i,
  input  logic             hs_rise_i,
  input  logic             vs_rise_i,
  input  logic [CNT_W-1:0] x_i,
  input  logic [CNT_W-1:0] y_i,
  input  logic             x_sat_i,
  input  logic             y_sat_i,
  output logic             locked_nxt_o
);

  localparam int TMO_W = tmo_width(TIMEOUT_CYC);
  localparam int M_W   = $clog2(LOCK_FRAMES + 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);
  localparam logic [M_W-1:0]   M_LIM   = M_W'(LOCK_FRAMES);

  lock_state_t      state_q, state_d;
  logic [CNT_W:0]   ref_len_q, ref_len_d;
  logic             ref_len_ok_q, ref_len_ok_d;
  logic [CNT_W-1:0] ref_lines_q, ref_lines_d;
  logic [M_W-1:0]   match_q, match_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             line_done_s, len_bad_s, sat_bad_s, frame_s, height_bad_s, timeout_s;
  logic [CNT_W:0]   line_len_s;
  logic [M_W-1:0]   match_inc_s;

  // x_i/y_i are the coordinates before this beat, so x_i+1 is the finished line's length
  assign line_done_s  = beat_i && hs_rise_i && (y_i != '0);
  assign line_len_s   = {1'b0, x_i} + (CNT_W+1)'(1);
  assign len_bad_s    = line_done_s && ref_len_ok_q && (line_len_s != ref_len_q);
  assign sat_bad_s    = beat_i && (x_sat_i || y_sat_i);
  assign frame_s      = beat_i && vs_rise_i;
  assign height_bad_s = (y_i != ref_lines_q);
  assign timeout_s    = (tmo_q >= TMO_LIM);
  assign match_inc_s  = match_q + M_W'(1);

  always_comb begin
    if (beat_i && hs_rise_i) begin
      tmo_d = '0;
    end else if (timeout_s) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    ref_len_d    = ref_len_q;
    ref_len_ok_d = ref_len_ok_q;
    ref_lines_d  = ref_lines_q;
    match_d      = match_q;
    if (timeout_s) begin
      state_d = UNLOCKED;
    end else begin
      case (state_q)
        UNLOCKED: begin
          if (frame_s) begin
            state_d      = MEASURE;
            ref_len_ok_d = 1'b0;
          end else begin
            state_d = UNLOCKED;
          end
        end
        MEASURE: begin
          if (len_bad_s || sat_bad_s) begin
            state_d = UNLOCKED;
          end else if (frame_s) begin
            state_d     = VERIFY;
            ref_lines_d = y_i;
            match_d     = '0;
          end else begin
            state_d = MEASURE;
          end
          if (line_done_s && !ref_len_ok_q) begin
            ref_len_d    = line_len_s;
            ref_len_ok_d = 1'b1;
          end else begin
            ref_len_ok_d = ref_len_ok_q;
          end
        end
        VERIFY: begin
          if (len_bad_s || sat_bad_s || (frame_s && height_bad_s)) begin
            state_d = UNLOCKED;
          end else if (frame_s && (match_inc_s == M_LIM)) begin
            state_d = LOCKED;
          end else if (frame_s) begin
            match_d = match_inc_s;
          end else begin
            state_d = VERIFY;
          end
        end
        LOCKED: begin
          if (len_bad_s || sat_bad_s || (frame_s && height_bad_s)) begin
            state_d = UNLOCKED;
          end else begin
            state_d = LOCKED;
          end
        end
        default: begin
          state_d = UNLOCKED;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= UNLOCKED;
      ref_len_q    <= '0;
      ref_len_ok_q <= 1'b0;
      ref_lines_q  <= '0;
      match_q      <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      ref_len_q    <= ref_len_d;
      ref_len_ok_q <= ref_len_ok_d;
      ref_lines_q  <= ref_lines_d;
      match_q      <= match_d;
      tmo_q        <= tmo_d;
    end
  end

  assign locked_nxt_o = (state_d == LOCKED);

endmodule

// File: rtl/cambus_timing.sv
// Regenerates pixel coordinates, blanking and lock status for a strobed
// camera stream that is already in the system clock domain.
module cambus_timing
  import cambus_pkg::*;
#(
  parameter int PIX_W       = 12,
  parameter int CNT_W       = 9,
  parameter int H_ACTIVE    = 320,
  parameter int V_FIRST     = 1,
  parameter int V_ACTIVE    = 256,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic             test_pattern,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pixel,
  output logic [CNT_W-1:0] out_x,
  output logic [CNT_W-1:0] out_y,
  output logic             out_hblank,
  output logic             out_vblank,
  output logic             out_visible,
  output logic             out_locked,
  output logic             out_sof
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   H_END   = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0]   V_LO    = (CNT_W+1)'(V_FIRST);
  localparam logic [CNT_W:0]   V_HI    = (CNT_W+1)'(V_FIRST + V_ACTIVE);

  logic             last_hs_q, last_vs_q;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             valid_q, hblank_q, vblank_q, visible_q, locked_q, sof_q;
  logic [PIX_W-1:0] pixel_q;

  logic             hs_rise_s, vs_rise_s, x_sat_s, y_sat_s, lock_nxt_s;
  logic             h_vis_s, v_vis_s, vis_s, sof_s;
  logic [CNT_W:0]   sum_s;
  logic [PIX_W-1:0] pix_s;

  assign hs_rise_s = in_valid && in_hsync && !last_hs_q;
  assign vs_rise_s = in_valid && in_vsync && !last_vs_q;
  assign x_sat_s   = in_valid && !hs_rise_s && (x_q == CNT_MAX);
  assign y_sat_s   = hs_rise_s && !vs_rise_s && (y_q == CNT_MAX);

  always_comb begin
    if (!in_valid) begin
      x_d = x_q;
    end else if (hs_rise_s) begin
      x_d = '0;
    end else if (x_q == CNT_MAX) begin
      x_d = x_q;
    end else begin
      x_d = x_q + CNT_W'(1);
    end
    // vsync restarts the frame even when hsync rises on the same beat
    if (!in_valid) begin
      y_d = y_q;
    end else if (vs_rise_s) begin
      y_d = '0;
    end else if (hs_rise_s && (y_q != CNT_MAX)) begin
      y_d = y_q + CNT_W'(1);
    end else begin
      y_d = y_q;
    end
  end

  cambus_lockfsm #(
    .CNT_W       (CNT_W),
    .LOCK_FRAMES (LOCK_FRAMES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_lockfsm (
    .clk          (clk),
    .rst          (rst),
    .beat_i       (in_valid),
    .hs_rise_i    (hs_rise_s),
    .vs_rise_i    (vs_rise_s),
    .x_i          (x_q),
    .y_i          (y_q),
    .x_sat_i      (x_sat_s),
    .y_sat_i      (y_sat_s),
    .locked_nxt_o (lock_nxt_s)
  );

  assign h_vis_s = ({1'b0, x_d} < H_END);
  assign v_vis_s = ({1'b0, y_d} >= V_LO) && ({1'b0, y_d} < V_HI);
  assign vis_s   = h_vis_s && v_vis_s && lock_nxt_s;
  assign sum_s   = {1'b0, x_d} + {1'b0, y_d};
  assign sof_s   = vis_s && (x_d == '0) && (y_d == CNT_W'(V_FIRST));

  always_comb begin
    if (!vis_s) begin
      pix_s = '0;
    end else if (test_pattern) begin
      pix_s = PIX_W'(sum_s);
    end else begin
      pix_s = in_pixel;
    end
  end

  // Beat-aligned output stage; locked tracks the FSM every cycle so a timeout drops it without a beat
  always_ff @(posedge clk) begin
    if (rst) begin
      last_hs_q <= 1'b0;
      last_vs_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      pixel_q   <= '0;
      hblank_q  <= 1'b1;
      vblank_q  <= 1'b1;
      visible_q <= 1'b0;
      locked_q  <= 1'b0;
      sof_q     <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      valid_q  <= in_valid;
      locked_q <= lock_nxt_s;
      if (in_valid) begin
        last_hs_q <= in_hsync;
        last_vs_q <= in_vsync;
        pixel_q   <= pix_s;
        hblank_q  <= !h_vis_s || !lock_nxt_s;
        vblank_q  <= !v_vis_s || !lock_nxt_s;
        visible_q <= vis_s;
        sof_q     <= sof_s;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_pixel   = pixel_q;
  assign out_x       = x_q;
  assign out_y       = y_q;
  assign out_hblank  = hblank_q;
  assign out_vblank  = vblank_q;
  assign out_visible = visible_q;
  assign out_locked  = locked_q;
  assign out_sof     = sof_q;

endmodule

// File: tb/tb_cambus_timing.sv
// Directed bench for cambus_timing using a reduced frame geometry
// (40-beat lines, 20-line frames, 32x16 visible window).
module tb_cambus_timing;

  localparam int PIX_W = 12;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [PIX_W-1:0] in_pixel;
  logic             in_hsync, in_vsync, test_pattern;
  logic             out_valid;
  logic [PIX_W-1:0] out_pixel;
  logic [CNT_W-1:0] out_x, out_y;
  logic             out_hblank, out_vblank, out_visible, out_locked, out_sof;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int   lines;
    int   short_l;
    int   probe;
    logic tp;
    int   lock_v;
    int   vis;
    int   sof;
  } vec_t;

  vec_t vecs [16];

  cambus_timing #(
    .PIX_W(PIX_W), .CNT_W(CNT_W), .H_ACTIVE(32), .V_FIRST(1), .V_ACTIVE(16),
    .LOCK_FRAMES(2), .TIMEOUT_CYC(4096)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .test_pattern(test_pattern),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_x(out_x), .out_y(out_y),
    .out_hblank(out_hblank), .out_vblank(out_vblank), .out_visible(out_visible),
    .out_locked(out_locked), .out_sof(out_sof)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_pixel"}, out_pixel, 0);
    check_eq({tag, "_x"}, out_x, 0);
    check_eq({tag, "_y"}, out_y, 0);
    check_eq({tag, "_hblank"}, out_hblank, 1);
    check_eq({tag, "_vblank"}, out_vblank, 1);
    check_eq({tag, "_visible"}, out_visible, 0);
    check_eq({tag, "_locked"}, out_locked, 0);
    check_eq({tag, "_sof"}, out_sof, 0);
  endtask

  task automatic beat(input logic hs, input logic vs, input logic [PIX_W-1:0] pix, input logic tp);
    in_valid     = 1'b1;
    in_hsync     = hs;
    in_vsync     = vs;
    in_pixel     = pix;
    test_pattern = tp;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input vec_t v, output int lock_v, output int lock_p,
                            output int sof_n, output int vis_n, output int bad_n,
                            output int px53, output int px35);
    int len;
    logic [PIX_W-1:0] pix, exp_px;
    lock_v = -1; lock_p = -1; sof_n = 0; vis_n = 0; bad_n = 0; px53 = -1; px35 = -1;
    for (int y = 0; y < v.lines; y++) begin
      len = (y == v.short_l) ? 39 : 40;
      for (int x = 0; x < len; x++) begin
        pix = PIX_W'((y << 6) | x);
        beat(x < 8, y < 2, pix, v.tp);
        if (x == 0 && y == 0) lock_v = out_locked;
        if (x == 0 && y == v.probe) lock_p = out_locked;
        if (x == 5 && y == 3) px53 = out_pixel;
        if (x == 35 && y == 3) px35 = out_pixel;
        if (out_sof) sof_n++;
        if (out_visible) begin
          vis_n++;
          exp_px = v.tp ? PIX_W'(x + y) : pix;
          if (out_x != CNT_W'(x) || out_y != CNT_W'(y) || out_x >= 32 ||
              out_y < 1 || out_y > 16 || out_pixel != exp_px) bad_n++;
        end
      end
    end
  endtask

  task automatic run_vec(input int i);
    int lv, lp, sn, vn, bn, p53, p35;
    send_frame(vecs[i], lv, lp, sn, vn, bn, p53, p35);
    check_eq($sformatf("f%0d_lock_at_vsync", i), lv, vecs[i].lock_v);
    check_eq($sformatf("f%0d_visible_beats", i), vn, vecs[i].vis);
    check_eq($sformatf("f%0d_sof_count", i), sn, vecs[i].sof);
    check_eq($sformatf("f%0d_visible_coords_pixels", i), bn, 0);
    if (vecs[i].probe >= 0) check_eq($sformatf("f%0d_lock_after_short_line", i), lp, 0);
    if (vecs[i].tp) begin
      check_eq($sformatf("f%0d_pattern_x5_y3", i), p53, 8);
      check_eq($sformatf("f%0d_pattern_x35_blank", i), p35, 0);
    end
  endtask

  initial begin
    // lines, short line, probe line, test pattern, lock at vsync, visible beats, sof count
    vecs[0]  = '{20, -1, -1, 1'b0, 0, 0,   0};
    vecs[1]  = '{20, -1, -1, 1'b0, 0, 0,   0};
    vecs[2]  = '{20, -1, -1, 1'b0, 0, 0,   0};
    vecs[3]  = '{20, -1, -1, 1'b0, 1, 512, 1};
    vecs[4]  = '{20, -1, -1, 1'b1, 1, 512, 1};
    vecs[5]  = '{20,  5,  6, 1'b0, 1, 160, 1};
    vecs[6]  = '{20, -1, -1, 1'b0, 0, 0,   0};
    vecs[7]  = '{20, -1, -1, 1'b0, 0, 0,   0};
    vecs[8]  = '{20, -1, -1, 1'b0, 0, 0,   0};
    vecs[9]  = '{20, -1, -1, 1'b0, 1, 512, 1};
    vecs[10] = '{19, -1, -1, 1'b0, 1, 512, 1};
    vecs[11] = '{20, -1, -1, 1'b0, 0, 0,   0};
    vecs[12] = '{20, -1, -1, 1'b0, 0, 0,   0};
    vecs[13] = '{20, -1, -1, 1'b0, 0, 0,   0};
    vecs[14] = '{20, -1, -1, 1'b0, 0, 0,   0};
    vecs[15] = '{20, -1, -1, 1'b0, 1, 512, 1};

    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; in_hsync = 1'b0; in_vsync = 1'b0;
    test_pattern = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(i);

    // Frame-start beat while locked, then stall the stream
    beat(1'b1, 1'b1, '0, 1'b0);
    check_eq("tmo_start_locked", out_locked, 1);
    check_eq("tmo_start_valid", out_valid, 1);
    in_valid = 1'b0;
    repeat (4096) @(posedge clk);
    #1;
    check_eq("tmo_4096_locked", out_locked, 1);
    check_eq("tmo_4096_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check_eq("tmo_4097_locked", out_locked, 0);
    check_eq("tmo_4097_valid", out_valid, 0);
    check_eq("tmo_x_hold", out_x, 0);

    beat(1'b0, 1'b0, '0, 1'b0);
    beat(1'b0, 1'b0, '0, 1'b0);
    check_eq("count_x2", out_x, 2);
    beat(1'b1, 1'b1, '0, 1'b0);
    check_eq("both_rise_x", out_x, 0);
    check_eq("both_rise_y", out_y, 0);
    beat(1'b0, 1'b0, '0, 1'b0);
    beat(1'b1, 1'b0, '0, 1'b0);
    check_eq("hs_rise_x", out_x, 0);
    check_eq("hs_rise_y", out_y, 1);
    for (int k = 0; k < 600; k++) beat(1'b0, 1'b0, '0, 1'b0);
    check_eq("x_saturate", out_x, 511);
    check_eq("x_saturate_y", out_y, 1);
    check_eq("x_saturate_hblank", out_hblank, 1);

    // Reset asserted mid-line, on a beat that would otherwise be an hsync rise
    beat(1'b0, 1'b0, 12'h0AB, 1'b0);
    rst = 1'b1;
    beat(1'b1, 1'b0, 12'h0CD, 1'b0);
    check_reset("midreset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) run_vec(i);

    in_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
